// File: rtl/self_check_pkg.sv
// Shared FSM encoding and default sizing for the register-file self-check harness.
package self_check_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_CYC_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPURST,
    ST_RUN,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
// Latency: count reflects inc/clr one cycle later. No backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/self_check_harness.sv
// Runs a CPU for num_cycles, then sweeps the register file against an expected-value ROM (trace: SELF_CHECK_TRACE_EN).
// Latency: done rises 1 + num_cycles + NUM_REGS + 1 cycles after the accepted start edge.
// Backpressure: none; start is only accepted in IDLE or DONE.
module self_check_harness
  import self_check_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int CYC_W    = DEF_CYC_W,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  output logic              cpu_reset,
  input  logic              rwe,
  input  logic [4:0]        rd,
  output logic              test_mode,
  output logic [IDX_W-1:0]  test_reg,
  input  logic [DATA_W-1:0] reg_data,
  output logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W:0]    error_count,
  output logic [CYC_W-1:0]  write_count,
`ifdef SELF_CHECK_TRACE_EN
  input  logic [DATA_W-1:0] data_writeReg,
  output logic              trace_valid,
  output logic [CYC_W-1:0]  trace_cycle,
  output logic [4:0]        trace_reg,
  output logic [DATA_W-1:0] trace_data,
`endif
  output logic              fail_valid,
  output logic [IDX_W-1:0]  fail_reg
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_e state_q, state_d;

  logic              in_run, in_sweep, in_cpurst;
  logic              start_acc, wr_mon, mismatch;
  logic [CYC_W-1:0]  num_q, num_d, cyc_q, cyc_d;
  logic [IDX_W-1:0]  idx_q, idx_d, cmp_idx_q, cmp_idx_d, fail_reg_q, fail_reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cmp_vld_q, cmp_vld_d, fail_valid_q, fail_valid_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_CPURST;
      ST_CPURST:        state_d = (num_q == '0) ? ST_SWEEP : ST_RUN;
      ST_RUN:           if (cyc_q == num_q - CYC_ONE) state_d = ST_SWEEP;
      ST_SWEEP:         if (idx_q == IDX_LAST) state_d = ST_DRAIN;
      ST_DRAIN:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_cpurst = (state_q == ST_CPURST);
    in_run    = (state_q == ST_RUN);
    in_sweep  = (state_q == ST_SWEEP);
    busy      = in_cpurst || in_run || in_sweep || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    test_mode = in_sweep || (state_q == ST_DRAIN);
    start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  assign cpu_reset = reset || in_cpurst;
  assign test_reg  = in_sweep ? idx_q : '0;
  assign exp_addr  = in_sweep ? idx_q : '0;
  assign wr_mon    = in_run && rwe && (rd != 5'd0);
  // Read data is captured with its index; the ROM word for that index arrives one cycle later.
  assign mismatch  = cmp_vld_q && (data_q != exp_data);

  always_comb begin
    num_d        = num_q;
    cyc_d        = cyc_q;
    idx_d        = idx_q;
    data_d       = data_q;
    cmp_idx_d    = cmp_idx_q;
    cmp_vld_d    = in_sweep;
    fail_valid_d = fail_valid_q;
    fail_reg_d   = fail_reg_q;
    if (start_acc) begin
      num_d        = num_cycles;
      cyc_d        = '0;
      idx_d        = '0;
      fail_valid_d = 1'b0;
      fail_reg_d   = '0;
    end else begin
      if (in_run) cyc_d = cyc_q + CYC_ONE;
      if (in_sweep) begin
        idx_d     = idx_q + IDX_W'(1);
        data_d    = reg_data;
        cmp_idx_d = idx_q;
      end
      if (mismatch && !fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_reg_d   = cmp_idx_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      num_q        <= '0;
      cyc_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      cmp_idx_q    <= '0;
      cmp_vld_q    <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
    end else begin
      num_q        <= num_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      cmp_idx_q    <= cmp_idx_d;
      cmp_vld_q    <= cmp_vld_d;
      fail_valid_q <= fail_valid_d;
      fail_reg_q   <= fail_reg_d;
    end
  end

  sat_counter #(.WIDTH(CYC_W)) u_write_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start_acc),
    .inc   (wr_mon),
    .count (write_count)
  );

  sat_counter #(.WIDTH(IDX_W + 1)) u_error_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start_acc),
    .inc   (mismatch),
    .count (error_count)
  );

  assign pass       = done && (error_count == '0);
  assign fail_valid = fail_valid_q;
  assign fail_reg   = fail_reg_q;

`ifdef SELF_CHECK_TRACE_EN
  logic              trace_valid_q, trace_valid_d;
  logic [CYC_W-1:0]  trace_cycle_q, trace_cycle_d;
  logic [4:0]        trace_reg_q, trace_reg_d;
  logic [DATA_W-1:0] trace_data_q, trace_data_d;

  always_comb begin
    trace_valid_d = wr_mon;
    trace_cycle_d = trace_cycle_q;
    trace_reg_d   = trace_reg_q;
    trace_data_d  = trace_data_q;
    if (wr_mon) begin
      trace_cycle_d = cyc_q;
      trace_reg_d   = rd;
      trace_data_d  = data_writeReg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
      trace_cycle_q <= '0;
      trace_reg_q   <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_cycle_q <= trace_cycle_d;
      trace_reg_q   <= trace_reg_d;
      trace_data_q  <= trace_data_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_cycle = trace_cycle_q;
  assign trace_reg   = trace_reg_q;
  assign trace_data  = trace_data_q;
`endif

endmodule

// File: tb/tb_self_check_harness.sv
// Directed bench: table of whole-test vectors plus reset-in-RUN, busy-start/saturation and trace sequences.
module tb_self_check_harness;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  // DUT 1: default sizing
  logic        start = 1'b0, rwe = 1'b0;
  logic [11:0] num_cycles = '0;
  logic [4:0]  rd = '0;
  logic        cpu_reset, test_mode, busy, done, pass, fail_valid;
  logic [4:0]  test_reg, exp_addr, fail_reg;
  logic [31:0] reg_data, exp_data;
  logic [5:0]  error_count;
  logic [11:0] write_count;

  // DUT 2: CYC_W = 4 for write-count saturation
  logic        start2 = 1'b0, rwe2 = 1'b0;
  logic [3:0]  num_cycles2 = '0;
  logic [4:0]  rd2 = '0;
  logic        cpu_reset2, test_mode2, busy2, done2, pass2, fail_valid2;
  logic [4:0]  test_reg2, exp_addr2, fail_reg2;
  logic [31:0] reg_data2, exp_data2;
  logic [5:0]  error_count2;
  logic [3:0]  write_count2;

`ifdef SELF_CHECK_TRACE_EN
  logic [31:0] data_writeReg = '0, trace_data, trace_data2;
  logic        trace_valid, trace_valid2;
  logic [11:0] trace_cycle;
  logic [3:0]  trace_cycle2;
  logic [4:0]  trace_reg, trace_reg2;
`endif

  logic [31:0] rf  [32];
  logic [31:0] rom [32];

  assign reg_data  = test_mode  ? rf[test_reg]  : 32'h0;
  assign reg_data2 = test_mode2 ? rf[test_reg2] : 32'h0;
  always @(posedge clock) begin
    exp_data  <= rom[exp_addr];
    exp_data2 <= rom[exp_addr2];
  end

  self_check_harness dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_reset(cpu_reset), .rwe(rwe), .rd(rd), .test_mode(test_mode),
    .test_reg(test_reg), .reg_data(reg_data), .exp_addr(exp_addr),
    .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .write_count(write_count),
`ifdef SELF_CHECK_TRACE_EN
    .data_writeReg(data_writeReg), .trace_valid(trace_valid),
    .trace_cycle(trace_cycle), .trace_reg(trace_reg), .trace_data(trace_data),
`endif
    .fail_valid(fail_valid), .fail_reg(fail_reg)
  );

  self_check_harness #(.CYC_W(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .num_cycles(num_cycles2),
    .cpu_reset(cpu_reset2), .rwe(rwe2), .rd(rd2), .test_mode(test_mode2),
    .test_reg(test_reg2), .reg_data(reg_data2), .exp_addr(exp_addr2),
    .exp_data(exp_data2), .busy(busy2), .done(done2), .pass(pass2),
    .error_count(error_count2), .write_count(write_count2),
`ifdef SELF_CHECK_TRACE_EN
    .data_writeReg(data_writeReg), .trace_valid(trace_valid2),
    .trace_cycle(trace_cycle2), .trace_reg(trace_reg2), .trace_data(trace_data2),
`endif
    .fail_valid(fail_valid2), .fail_reg(fail_reg2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // wr_at is the RUN-cycle index counted from the first RUN cycle; indices >= num land in SWEEP.
  typedef struct packed {
    logic [11:0]       num;
    logic [3:0]        wr_en;
    logic [3:0][7:0]   wr_at;
    logic [3:0][4:0]   wr_rd;
    logic [31:0]       bad;
    logic [7:0]        done_at;
    logic [11:0]       wc;
    logic [5:0]        ec;
    logic              fv;
    logic [4:0]        fr;
    logic              ps;
  } vec_t;

  vec_t vt [5];

  task automatic load_rom(input logic [31:0] bad);
    for (int i = 0; i < 32; i++) rom[i] = rf[i] ^ (bad[i] ? (32'h1 << i) : 32'h0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int done_at = 0;
    int busy_err = 0;
    logic [11:0] wc_hold;
    load_rom(v.bad);
    @(negedge clock);
    start = 1'b1;
    num_cycles = v.num;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk($sformatf("v%0d cpu_reset in CPURST", id), cpu_reset, 1);
    for (int e = 1; e < 200; e++) begin
      @(posedge clock);
      #1;
      rwe = 1'b0;
      rd  = 5'd0;
      for (int w = 0; w < 4; w++)
        if (v.wr_en[w] && (int'(v.wr_at[w]) == e - 1)) begin
          rwe = 1'b1;
          rd  = v.wr_rd[w];
        end
      @(negedge clock);
      if (e == 1) chk($sformatf("v%0d cpu_reset after CPURST", id), cpu_reset, 0);
      if (e == int'(v.num) + 1)
        chk($sformatf("v%0d first sweep mode/reg", id), {test_mode, test_reg}, {1'b1, 5'd0});
      if (e == int'(v.num) + 6)
        chk($sformatf("v%0d sweep exp_addr", id), exp_addr, 5);
      if (done) begin
        done_at = e;
        break;
      end
      if (!busy) busy_err++;
    end
    rwe = 1'b0;
    chk($sformatf("v%0d done cycle", id), done_at, v.done_at);
    chk($sformatf("v%0d busy until done", id), busy_err, 0);
    chk($sformatf("v%0d write_count", id), write_count, v.wc);
    chk($sformatf("v%0d error_count", id), error_count, v.ec);
    chk($sformatf("v%0d fail_valid/fail_reg", id), {fail_valid, fail_reg}, {v.fv, v.fr});
    chk($sformatf("v%0d pass", id), pass, v.ps);
    wc_hold = write_count;
    repeat (3) @(negedge clock);
    chk($sformatf("v%0d results hold", id), {done, busy, write_count}, {1'b1, 1'b0, wc_hold});
  endtask

  initial begin
    int done_at;
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 + 32'(i * 7);
    load_rom(32'h0);

    vt[0] = '{num: 12'd10, wr_en: 4'b1111, wr_at: {8'd5, 8'd4, 8'd3, 8'd2},
              wr_rd: {5'd0, 5'd3, 5'd2, 5'd1}, bad: 32'h0,
              done_at: 8'd44, wc: 12'd3, ec: 6'd0, fv: 1'b0, fr: 5'd0, ps: 1'b1};
    vt[1] = '{num: 12'd10, wr_en: 4'b0000, wr_at: '0, wr_rd: '0, bad: 32'h0002_0020,
              done_at: 8'd44, wc: 12'd0, ec: 6'd2, fv: 1'b1, fr: 5'd5, ps: 1'b0};
    vt[2] = '{num: 12'd0, wr_en: 4'b0000, wr_at: '0, wr_rd: '0, bad: 32'h0,
              done_at: 8'd34, wc: 12'd0, ec: 6'd0, fv: 1'b0, fr: 5'd0, ps: 1'b1};
    vt[3] = '{num: 12'd3, wr_en: 4'b0111, wr_at: {8'd0, 8'd5, 8'd2, 8'd0},
              wr_rd: {5'd0, 5'd4, 5'd31, 5'd31}, bad: 32'h8000_0001,
              done_at: 8'd37, wc: 12'd2, ec: 6'd2, fv: 1'b1, fr: 5'd0, ps: 1'b0};
    vt[4] = '{num: 12'd1, wr_en: 4'b0001, wr_at: {8'd0, 8'd0, 8'd0, 8'd0},
              wr_rd: {5'd0, 5'd0, 5'd0, 5'd1}, bad: 32'hFFFF_FFFF,
              done_at: 8'd35, wc: 12'd1, ec: 6'd32, fv: 1'b1, fr: 5'd0, ps: 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("cpu_reset during reset", cpu_reset, 1);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("idle outputs after reset",
        {busy, done, pass, cpu_reset, test_mode, fail_valid, error_count, write_count, test_reg, exp_addr, fail_reg}, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    // Reset in RUN cycle 20, with a coincident start that must be ignored
    load_rom(32'h0);
    @(negedge clock);
    start = 1'b1;
    num_cycles = 12'd40;
    @(posedge clock);
    #1 start = 1'b0;
    rwe = 1'b1;
    rd  = 5'd2;
    repeat (21) @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    chk("write_count before mid-run reset", write_count, 20);
    chk("cpu_reset follows reset in RUN", cpu_reset, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    rwe   = 1'b0;
    @(negedge clock);
    chk("outputs after mid-run reset",
        {busy, done, pass, cpu_reset, test_mode, fail_valid, error_count, write_count, test_reg, exp_addr, fail_reg}, 0);
    run_vec(5, vt[0]);

    // Saturation on a 4-bit write counter; start while busy is ignored
    load_rom(32'h0);
    @(negedge clock);
    start2 = 1'b1;
    num_cycles2 = 4'd15;
    rwe2 = 1'b1;
    rd2  = 5'd7;
    @(posedge clock);
    #1 start2 = 1'b0;
    done_at = 0;
    for (int e = 1; e < 200; e++) begin
      @(posedge clock);
      #1;
      start2 = (e == 6);
      num_cycles2 = (e == 6) ? 4'd3 : 4'd15;
      @(negedge clock);
      if (done2) begin
        done_at = e;
        break;
      end
    end
    chk("sat done cycle (busy start ignored)", done_at, 49);
    chk("sat write_count", write_count2, 15);
    chk("sat pass", pass2, 1);
    repeat (3) @(negedge clock);
    rwe2 = 1'b0;
    chk("sat write_count holds", write_count2, 15);

`ifdef SELF_CHECK_TRACE_EN
    @(negedge clock);
    start = 1'b1;
    num_cycles = 12'd8;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    rwe = 1'b1;
    rd  = 5'd9;
    data_writeReg = 32'hDEADBEEF;
    @(negedge clock);
    chk("trace idle before write", trace_valid, 0);
    @(posedge clock);
    #1 rwe = 1'b0;
    @(negedge clock);
    chk("trace record", {trace_valid, trace_cycle, trace_reg, trace_data}, {1'b1, 12'd4, 5'd9, 32'hDEADBEEF});
    @(negedge clock);
    chk("trace valid drops", trace_valid, 0);
    done_at = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clock);
      if (done) begin
        done_at = 1;
        break;
      end
    end
    chk("trace run completes", done_at, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
